ramp_adc_sequencer: RTL and testbench

RAMP_ADC_SEQUENCER -- requirements
Module: ramp_adc_sequencer

---
 rtl/ramp_adc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ramp_adc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_adc_sequencer.sv
// Two-channel single-slope ADC sequencer: settles the analog mux, times comparator
// falling edges against an external sawtooth and averages 2^AVG_LOG2 samples per result.
module ramp_adc_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       chan_en,
  input  logic [1:0]       comp_in,
  input  logic [WIDTH-1:0] ramp_value,
  input  logic             ramp_wrap,
  output logic             ramp_enable,
  output logic             chan_sel,
  output logic             busy,
  output logic [WIDTH-1:0] result_data,
  output logic             result_chan,
  output logic             result_overrange,
  output logic             result_valid,
  output logic [2:0]       dbg_state
);

  // Handshake: result_valid is a one-cycle strobe with no back-pressure; result_data,
  // result_chan and result_overrange change only in the cycle result_valid is high.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_WAIT_WRAP = 3'd2,
    S_TRACK     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(2 ** AVG_LOG2);
  localparam logic [ACC_W-1:0] TIMEOUT_VAL = ACC_W'({WIDTH{1'b1}});

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic               chan_q, chan_d;
  logic               last_chan_q, last_chan_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               res_chan_q, res_chan_d;
  logic               res_ovr_q, res_ovr_d;
  logic               res_valid_q, res_valid_d;
  logic [1:0]         comp_s1_q, comp_s2_q, comp_prev_q;

  logic               fall;
  logic               start_ok;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_sample;

  // Round-robin over two channels: prefer the other one, else repeat the same one.
  function automatic logic pick_chan(input logic last, input logic [1:0] en);
    return en[~last] ? ~last : last;
  endfunction

  assign fall        = comp_prev_q[chan_q] & ~comp_s2_q[chan_q];
  assign start_ok    = run & (|chan_en);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign last_sample = (cnt_inc == N_SAMPLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      chan_q      <= 1'b0;
      last_chan_q <= 1'b1;
      res_data_q  <= '0;
      res_chan_q  <= 1'b0;
      res_ovr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      comp_s1_q   <= '0;
      comp_s2_q   <= '0;
      comp_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      chan_q      <= chan_d;
      last_chan_q <= last_chan_d;
      res_data_q  <= res_data_d;
      res_chan_q  <= res_chan_d;
      res_ovr_q   <= res_ovr_d;
      res_valid_q <= res_valid_d;
      comp_s1_q   <= comp_in;
      comp_s2_q   <= comp_s1_q;
      comp_prev_q <= comp_s2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    chan_d      = chan_q;
    last_chan_d = last_chan_q;
    res_data_d  = res_data_q;
    res_chan_d  = res_chan_q;
    res_ovr_d   = res_ovr_q;
    res_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          chan_d   = pick_chan(last_chan_q, chan_en);
          acc_d    = '0;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_WAIT_WRAP;
        else                         settle_d = settle_q + SET_W'(1);
      end
      S_WAIT_WRAP: begin
        if (ramp_wrap) state_d = S_TRACK;
      end
      S_TRACK: begin
        // An edge wins over a coincident wrap: the capture is still valid.
        if (fall) begin
          acc_d   = acc_q + ACC_W'(ramp_value);
          cnt_d   = cnt_inc;
          state_d = last_sample ? S_DONE : S_WAIT_WRAP;
        end else if (ramp_wrap) begin
          acc_d   = acc_q + TIMEOUT_VAL;
          ovr_d   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = last_sample ? S_DONE : S_TRACK;
        end
      end
      S_DONE: begin
        res_data_d  = WIDTH'(acc_q >> AVG_LOG2);
        res_chan_d  = chan_q;
        res_ovr_d   = ovr_q;
        res_valid_d = 1'b1;
        last_chan_d = chan_q;
        if (start_ok) begin
          chan_d   = pick_chan(chan_q, chan_en);
          acc_d    = '0;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    ramp_enable      = (state_q != S_IDLE);
    dbg_state        = state_q;
    chan_sel         = chan_q;
    result_data      = res_data_q;
    result_chan      = res_chan_q;
    result_overrange = res_ovr_q;
    result_valid     = res_valid_q;
  end

endmodule

// File: tb/tb_ramp_adc_sequencer.sv
// Directed bench for ramp_adc_sequencer: scripted ramps/comparator edges, results
// collected by a monitor and matched against hand-computed expectations.
module tb_ramp_adc_sequencer;

  localparam int SETTLE = 8;

  logic       clk;
  logic       reset;
  logic       run;
  logic [1:0] chan_en;
  logic [1:0] comp_in;
  logic [7:0] ramp_value;
  logic       ramp_wrap;
  logic       ramp_enable;
  logic       chan_sel;
  logic       busy;
  logic [7:0] result_data;
  logic       result_chan;
  logic       result_overrange;
  logic       result_valid;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {overrange, chan, data}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  ramp_adc_sequencer #(
    .WIDTH         (8),
    .AVG_LOG2      (2),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .chan_en          (chan_en),
    .comp_in          (comp_in),
    .ramp_value       (ramp_value),
    .ramp_wrap        (ramp_wrap),
    .ramp_enable      (ramp_enable),
    .chan_sel         (chan_sel),
    .busy             (busy),
    .result_data      (result_data),
    .result_chan      (result_chan),
    .result_overrange (result_overrange),
    .result_valid     (result_valid),
    .dbg_state        (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (result_valid === 1'b1) got_q.push_back({result_overrange, result_chan, result_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: comparator falls at v; 1: no fall (timeout); 2: fall detected together with a wrap
  task automatic do_ramp(input logic [7:0] v, input int mode, input bit drop_run);
    @(negedge clk); ramp_value = 8'h00; ramp_wrap = 1'b1; comp_in = 2'b11;
    @(negedge clk); ramp_wrap = 1'b0; ramp_value = v;
    if (drop_run) run = 1'b0;
    @(negedge clk); if (mode != 1) comp_in = 2'b00;
    @(negedge clk);
    @(negedge clk); if (mode == 2) ramp_wrap = 1'b1;
    @(negedge clk); ramp_wrap = 1'b0;
    tick(2);
    @(negedge clk); comp_in = 2'b11;
    tick(3);
  endtask

  task automatic sb_drain(input string tag);
    logic [9:0] g;
    logic [9:0] e;
    check_eq({tag, "_pulses"}, got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_eq({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
      check_eq({tag, "_chan"}, 32'(g[8]), 32'(e[8]));
      check_eq({tag, "_ovr"},  32'(g[9]), 32'(e[9]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] rr_val [4] = '{8'h20, 8'h30, 8'h40, 8'h50};
  logic       rr_chan[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] ramp_seq[4] = '{8'h10, 8'h11, 8'h12, 8'h13};

  initial begin
    reset = 1'b1; run = 1'b0; chan_en = 2'b00; comp_in = 2'b11;
    ramp_value = 8'h00; ramp_wrap = 1'b0;
    tick(3);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_ramp",  ramp_enable, 0);
    check_eq("rst_sel",   chan_sel, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_data",  result_data, 0);
    check_eq("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick(4);

    // Single channel, comparator falls at 0x80 every ramp; settle length checked exactly.
    chan_en = 2'b01; run = 1'b1;
    tick(SETTLE);
    check_eq("settle_state", dbg_state, 1);
    tick(1);
    check_eq("wait_state", dbg_state, 2);
    check_eq("conv_busy", busy, 1);
    check_eq("conv_ramp", ramp_enable, 1);
    check_eq("conv_sel0", chan_sel, 0);
    tick(3);
    exp_q.push_back({1'b0, 1'b0, 8'h80});
    do_ramp(8'h80, 0, 1'b0);
    do_ramp(8'h80, 0, 1'b0);
    chan_en = 2'b10;
    do_ramp(8'h80, 0, 1'b0);
    check_eq("en_change_sel", chan_sel, 0);
    chan_en = 2'b01;
    do_ramp(8'h80, 0, 1'b0);
    tick(2);
    sb_drain("avg80");

    // Unequal captures: 0x10+0x11+0x12+0x13 = 0x46 -> 0x11
    tick(SETTLE + 4);
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    for (int i = 0; i < 4; i++) do_ramp(ramp_seq[i], 0, 1'b0);
    tick(2);
    sb_drain("avg_seq");

    // Comparator held high: first wrap enters TRACK, the next four time out
    tick(SETTLE + 4);
    exp_q.push_back({1'b1, 1'b0, 8'hFF});
    for (int i = 0; i < 5; i++) do_ramp(8'h80, 1, 1'b0);
    tick(2);
    sb_drain("timeout");

    // Edge coincident with wrap at 0xFE counts as a capture
    tick(SETTLE + 4);
    exp_q.push_back({1'b0, 1'b0, 8'hFE});
    for (int i = 0; i < 4; i++) do_ramp(8'hFE, 2, 1'b0);
    tick(2);
    sb_drain("coincident");

    reset = 1'b1; run = 1'b0;
    tick(2);
    check_eq("rst2_data", result_data, 0);
    check_eq("rst2_state", dbg_state, 0);
    reset = 1'b0;
    tick(2);

    // Round robin over both channels; run dropped mid-TRACK in the last conversion
    chan_en = 2'b11; run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(SETTLE + 4);
      check_eq($sformatf("rr_sel%0d", c), chan_sel, rr_chan[c]);
      exp_q.push_back({1'b0, rr_chan[c], rr_val[c]});
      for (int i = 0; i < 4; i++) do_ramp(rr_val[c], 0, (c == 3) && (i == 2));
      tick(2);
      sb_drain($sformatf("rr%0d", c));
    end
    tick(4);
    check_eq("drop_busy",  busy, 0);
    check_eq("drop_ramp",  ramp_enable, 0);
    check_eq("drop_state", dbg_state, 0);
    check_eq("hold_data",  result_data, 8'h50);
    check_eq("hold_chan",  result_chan, 1);

    // Reset mid-TRACK on channel 1 discards the partial conversion
    chan_en = 2'b10; run = 1'b1;
    tick(SETTLE + 4);
    check_eq("abort_sel1", chan_sel, 1);
    do_ramp(8'h60, 0, 1'b0);
    do_ramp(8'h60, 0, 1'b0);
    @(negedge clk); ramp_value = 8'h00; ramp_wrap = 1'b1;
    @(negedge clk); ramp_wrap = 1'b0; ramp_value = 8'h60;
    check_eq("abort_track", dbg_state, 3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy",  busy, 0);
    check_eq("abort_ramp",  ramp_enable, 0);
    check_eq("abort_sel",   chan_sel, 0);
    check_eq("abort_data",  result_data, 0);
    check_eq("abort_chan",  result_chan, 0);
    check_eq("abort_ovr",   result_overrange, 0);
    check_eq("abort_valid", result_valid, 0);
    reset = 1'b0; run = 1'b0;
    tick(20);
    sb_drain("abort");

    // run with no channel enabled stays idle
    chan_en = 2'b00; run = 1'b1;
    tick(10);
    check_eq("noen_busy",  busy, 0);
    check_eq("noen_state", dbg_state, 0);
    run = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
